mii_rx_frame_decoder: RTL and testbench



---
 rtl/mii_rx_frame_decoder.sv | 164 ++++++++++++++++
 tb/tb_mii_rx_frame_decoder.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/mii_rx_frame_decoder.sv
// MII receive front end: nibble-to-byte assembly, preamble/SFD strip, FCS/runt/oversize/rx_er/dribble checks.
// Optional build macro MII_RX_FCS_STRIP_EN holds back the 4 FCS bytes so o_last marks the final payload byte.
module mii_rx_frame_decoder #(
  parameter int MAX_FRAME_BYTES = 1518
) (
  input  logic        i_clock,
  input  logic        i_reset_n,
  input  logic [3:0]  i_rx_d,
  input  logic        i_rx_dv,
  input  logic        i_rx_er,
  output logic [7:0]  o_data,
  output logic        o_valid,
  output logic        o_last,
  output logic        o_frame_done,
  output logic [4:0]  o_status,
  output logic [10:0] o_byte_count
);

`ifdef MII_RX_FCS_STRIP_EN
  localparam int PIPE_DEPTH = 5;
`else
  localparam int PIPE_DEPTH = 1;
`endif
  localparam logic [31:0] CRC_POLY    = 32'hEDB8_8320;
  localparam logic [31:0] CRC_RESIDUE = 32'hDEBB_20E3;
  localparam logic [10:0] MAX_BYTES   = 11'(MAX_FRAME_BYTES);
  localparam logic [10:0] BYTE_SAT    = 11'(MAX_FRAME_BYTES + 1);
  localparam logic [2:0]  PIPE_FULL   = 3'(PIPE_DEPTH);

  // The END step is folded into the DATA cycle that samples dv=0, so it overlaps the first IDLE cycle.
  typedef enum logic [1:0] {ST_WAIT_IDLE, ST_IDLE, ST_PREAMBLE, ST_DATA} state_e;

  state_e      state_q, state_d;
  logic        phase_q, phase_d;
  logic [3:0]  low_q, low_d;
  logic [31:0] crc_q, crc_d;
  logic        rx_er_q, rx_er_d;
  logic [10:0] byte_cnt_q, byte_cnt_d;
  logic [2:0]  fill_q, fill_d;
  logic [7:0]  pipe_q [PIPE_DEPTH];
  logic [7:0]  pipe_d [PIPE_DEPTH];
  logic [7:0]  data_q, data_d;
  logic        valid_q, valid_d;
  logic        last_q, last_d;
  logic        done_q, done_d;
  logic [4:0]  status_q, status_d;
  logic [10:0] count_q, count_d;

  function automatic logic [31:0] crc_nibble(input logic [31:0] crc, input logic [3:0] nib);
    logic [31:0] c;
    c = crc ^ {28'd0, nib};
    for (int i = 0; i < 4; i++) c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
    return c;
  endfunction

  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    low_d      = low_q;
    crc_d      = crc_q;
    rx_er_d    = rx_er_q;
    byte_cnt_d = byte_cnt_q;
    fill_d     = fill_q;
    pipe_d     = pipe_q;
    data_d     = data_q;
    valid_d    = 1'b0;
    last_d     = 1'b0;
    done_d     = 1'b0;
    status_d   = status_q;
    count_d    = count_q;
    case (state_q)
      ST_WAIT_IDLE: if (!i_rx_dv) state_d = ST_IDLE;
      ST_IDLE: if (i_rx_dv) state_d = (i_rx_d == 4'h5) ? ST_PREAMBLE : ST_WAIT_IDLE;
      ST_PREAMBLE: begin
        if (!i_rx_dv) state_d = ST_IDLE;
        else if (i_rx_d == 4'hD) begin
          state_d    = ST_DATA;
          phase_d    = 1'b0;
          crc_d      = 32'hFFFF_FFFF;
          rx_er_d    = 1'b0;
          byte_cnt_d = 11'd0;
          fill_d     = 3'd0;
        end else if (i_rx_d != 4'h5) state_d = ST_WAIT_IDLE;
      end
      ST_DATA: begin
        if (i_rx_dv) begin
          crc_d = crc_nibble(crc_q, i_rx_d);
          if (i_rx_er) rx_er_d = 1'b1;
          if (!phase_q) begin
            low_d   = i_rx_d;
            phase_d = 1'b1;
          end else begin
            phase_d = 1'b0;
            if (byte_cnt_q != BYTE_SAT) byte_cnt_d = byte_cnt_q + 11'd1;
            // A full pipeline releases its oldest byte as the new one enters.
            if (fill_q == PIPE_FULL) begin
              data_d  = pipe_q[PIPE_DEPTH-1];
              valid_d = 1'b1;
            end else begin
              fill_d = fill_q + 3'd1;
            end
            pipe_d[0] = {i_rx_d, low_q};
            for (int i = 1; i < PIPE_DEPTH; i++) pipe_d[i] = pipe_q[i-1];
          end
        end else begin
          state_d  = ST_IDLE;
          done_d   = 1'b1;
          status_d = {byte_cnt_q > MAX_BYTES, byte_cnt_q < 11'd64, phase_q, rx_er_q,
                      crc_q != CRC_RESIDUE};
          count_d  = byte_cnt_q;
          fill_d   = 3'd0;
          if (fill_q == PIPE_FULL) begin
            data_d  = pipe_q[PIPE_DEPTH-1];
            valid_d = 1'b1;
            last_d  = 1'b1;
          end
        end
      end
      default: state_d = ST_WAIT_IDLE;
    endcase
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q    <= ST_WAIT_IDLE;
      phase_q    <= 1'b0;
      low_q      <= 4'd0;
      crc_q      <= 32'hFFFF_FFFF;
      rx_er_q    <= 1'b0;
      byte_cnt_q <= 11'd0;
      fill_q     <= 3'd0;
      for (int i = 0; i < PIPE_DEPTH; i++) pipe_q[i] <= 8'd0;
      data_q     <= 8'd0;
      valid_q    <= 1'b0;
      last_q     <= 1'b0;
      done_q     <= 1'b0;
      status_q   <= 5'd0;
      count_q    <= 11'd0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      low_q      <= low_d;
      crc_q      <= crc_d;
      rx_er_q    <= rx_er_d;
      byte_cnt_q <= byte_cnt_d;
      fill_q     <= fill_d;
      pipe_q     <= pipe_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      last_q     <= last_d;
      done_q     <= done_d;
      status_q   <= status_d;
      count_q    <= count_d;
    end
  end

  assign o_data       = data_q;
  assign o_valid      = valid_q;
  assign o_last       = last_q;
  assign o_frame_done = done_q;
  assign o_status     = status_q;
  assign o_byte_count = count_q;

endmodule

// File: tb/tb_mii_rx_frame_decoder.sv
// Directed bench for mii_rx_frame_decoder: frames built with a bytewise FCS model, byte and frame
// scoreboards filled at drive time and drained by a negedge monitor.
module tb_mii_rx_frame_decoder;
  localparam int MAX_FRAME_BYTES = 1518;

  logic        i_clock = 1'b0;
  logic        i_reset_n = 1'b0;
  logic [3:0]  i_rx_d = 4'h0;
  logic        i_rx_dv = 1'b0;
  logic        i_rx_er = 1'b0;
  logic [7:0]  o_data;
  logic        o_valid;
  logic        o_last;
  logic        o_frame_done;
  logic [4:0]  o_status;
  logic [10:0] o_byte_count;

  int checks = 0;
  int failures = 0;
  bit mon_en = 1'b1;

  logic [8:0]  exp_q[$];   // {last, data}
  logic [20:0] exp_f[$];   // {status mask, status, byte count}
  logic [7:0]  frm [0:1599];

  mii_rx_frame_decoder #(.MAX_FRAME_BYTES(MAX_FRAME_BYTES)) dut (
    .i_clock(i_clock), .i_reset_n(i_reset_n), .i_rx_d(i_rx_d), .i_rx_dv(i_rx_dv),
    .i_rx_er(i_rx_er), .o_data(o_data), .o_valid(o_valid), .o_last(o_last),
    .o_frame_done(o_frame_done), .o_status(o_status), .o_byte_count(o_byte_count)
  );

  always #20 i_clock = ~i_clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge i_clock) begin
    if (mon_en && i_reset_n) begin
      if (o_valid) begin
        check("byte_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) check("last_data", 32'({o_last, o_data}), 32'(exp_q.pop_front()));
      end else begin
        check("last_without_valid", 32'(o_last), 32'd0);
      end
      if (o_frame_done) begin
        logic [20:0] rec;
        check("frame_expected", 32'(exp_f.size() != 0), 32'd1);
        if (exp_f.size() != 0) begin
          rec = exp_f.pop_front();
          check("status", 32'(o_status & rec[20:16]), 32'(rec[15:11] & rec[20:16]));
          check("byte_count", 32'(o_byte_count), 32'(rec[10:0]));
        end
      end
    end
  end

  task automatic check_reset_outputs();
    check("rst_data", 32'(o_data), 32'd0);
    check("rst_valid", 32'(o_valid), 32'd0);
    check("rst_last", 32'(o_last), 32'd0);
    check("rst_done", 32'(o_frame_done), 32'd0);
    check("rst_status", 32'(o_status), 32'd0);
    check("rst_count", 32'(o_byte_count), 32'd0);
  endtask

  task automatic drive_nib(input logic dv, input logic [3:0] d, input logic er);
    @(posedge i_clock);
    #1;
    i_rx_dv = dv;
    i_rx_d  = d;
    i_rx_er = er;
  endtask

  task automatic drive_preamble();
    for (int i = 0; i < 15; i++) drive_nib(1'b1, 4'h5, 1'b0);
    drive_nib(1'b1, 4'hD, 1'b0);
  endtask

  task automatic fill_arp();
    logic [7:0] hdr [0:41];
    hdr = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h08, 8'h00, 8'h27, 8'hE9, 8'h5E, 8'h81,
            8'h08, 8'h06, 8'h00, 8'h01, 8'h08, 8'h00, 8'h06, 8'h04, 8'h00, 8'h01,
            8'h08, 8'h00, 8'h27, 8'hE9, 8'h5E, 8'h81, 8'hC0, 8'hA8, 8'h01, 8'h0A,
            8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hC0, 8'hA8, 8'h01, 8'h01};
    for (int i = 0; i < 60; i++) frm[i] = (i < 42) ? hdr[i] : 8'h00;
  endtask

  task automatic fill_random(input int n);
    for (int i = 0; i < n; i++) frm[i] = 8'($urandom_range(0, 255));
  endtask

  // Standard Ethernet FCS over frm[0..n-5], appended LSB first.
  task automatic add_fcs(input int n);
    logic [31:0] c;
    c = 32'hFFFF_FFFF;
    for (int i = 0; i < n - 4; i++) begin
      c = c ^ {24'd0, frm[i]};
      for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
    end
    c = ~c;
    frm[n-4] = c[7:0];
    frm[n-3] = c[15:8];
    frm[n-2] = c[23:16];
    frm[n-1] = c[31:24];
  endtask

  task automatic send_frame(input int n, input int er_byte, input bit dribble,
                            input logic [4:0] st, input logic [4:0] mask, input int gap);
    int n_out;
    logic [10:0] cnt;
`ifdef MII_RX_FCS_STRIP_EN
    n_out = (n >= 5) ? n - 4 : 0;
`else
    n_out = n;
`endif
    for (int i = 0; i < n_out; i++) exp_q.push_back({(i == n_out - 1), frm[i]});
    cnt = (n > MAX_FRAME_BYTES) ? 11'(MAX_FRAME_BYTES + 1) : 11'(n);
    exp_f.push_back({mask, st, cnt});
    drive_preamble();
    for (int i = 0; i < n; i++) begin
      drive_nib(1'b1, frm[i][3:0], i == er_byte);
      drive_nib(1'b1, frm[i][7:4], i == er_byte);
    end
    if (dribble) drive_nib(1'b1, 4'hA, 1'b0);
    for (int i = 0; i < gap; i++) drive_nib(1'b0, 4'h0, 1'b0);
  endtask

  initial begin
    repeat (3) @(posedge i_clock);
    @(negedge i_clock);
    check_reset_outputs();
    @(posedge i_clock);
    #1 i_reset_n = 1'b1;
    repeat (3) drive_nib(1'b0, 4'h0, 1'b0);

    // Good ARP request
    fill_arp(); add_fcs(64);
    send_frame(64, -1, 1'b0, 5'b00000, 5'b11111, 6);
    // Single payload bit flipped after FCS computed
    fill_arp(); add_fcs(64); frm[20] = frm[20] ^ 8'h10;
    send_frame(64, -1, 1'b0, 5'b00001, 5'b11111, 6);
    // rx_er on byte 20
    fill_arp(); add_fcs(64);
    send_frame(64, 20, 1'b0, 5'b00010, 5'b11111, 6);
    // Trailing extra nibble; CRC outcome of the dribbled nibble is not asserted
    fill_arp(); add_fcs(64);
    send_frame(64, -1, 1'b1, 5'b00100, 5'b11110, 6);
    // Runt with valid FCS
    fill_random(36); add_fcs(40);
    send_frame(40, -1, 1'b0, 5'b01000, 5'b11111, 6);
    // Oversize
    fill_random(1518); add_fcs(1522);
    send_frame(1522, -1, 1'b0, 5'b10000, 5'b11111, 6);

    // Broken preamble: the remainder with dv high must be ignored
    drive_nib(1'b1, 4'h5, 1'b0); drive_nib(1'b1, 4'h5, 1'b0);
    drive_nib(1'b1, 4'h5, 1'b0); drive_nib(1'b1, 4'h5, 1'b0);
    drive_nib(1'b1, 4'h3, 1'b0);
    drive_preamble();
    for (int i = 0; i < 20; i++) drive_nib(1'b1, 4'($urandom_range(0, 15)), 1'b0);
    repeat (2) drive_nib(1'b0, 4'h0, 1'b0);
    fill_random(60); add_fcs(64);
    send_frame(64, -1, 1'b0, 5'b00000, 5'b11111, 6);

    // Reset mid-frame, released with dv still high
    mon_en = 1'b0;
    drive_preamble();
    for (int i = 0; i < 20; i++) drive_nib(1'b1, 4'($urandom_range(0, 15)), 1'b0);
    @(posedge i_clock);
    #1 i_reset_n = 1'b0;
    drive_nib(1'b1, 4'h5, 1'b0);
    @(negedge i_clock);
    check_reset_outputs();
    mon_en = 1'b1;
    drive_nib(1'b1, 4'h5, 1'b0);
    i_reset_n = 1'b1;
    drive_preamble();
    for (int i = 0; i < 40; i++) drive_nib(1'b1, 4'($urandom_range(0, 15)), 1'b0);
    repeat (2) drive_nib(1'b0, 4'h0, 1'b0);
    fill_arp(); add_fcs(64);
    send_frame(64, -1, 1'b0, 5'b00000, 5'b11111, 6);

    // Back-to-back with a single dv=0 cycle
    fill_random(60); add_fcs(64);
    send_frame(64, -1, 1'b0, 5'b00000, 5'b11111, 1);
    fill_random(80); add_fcs(84);
    send_frame(84, -1, 1'b0, 5'b00000, 5'b11111, 6);

    for (int i = 0; i < 100 && (exp_q.size() != 0 || exp_f.size() != 0); i++) @(posedge i_clock);
    @(negedge i_clock);
    check("bytes_drained", 32'(exp_q.size()), 32'd0);
    check("frames_drained", 32'(exp_f.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
